lfsr_rng: RTL

Parametrised XNOR Fibonacci LFSR with a maximal-length tap table for widths 3..16, seed load and all-ones lock-up recovery. Adds a request/valid/ack draw port that returns an unbiased value in 0..RANGE-1 by rejection sampling. It serves as the game-wide random source for prompt/colour/direction selection and replaces the fixed 3-bit generator.

---
 rtl/lfsr_pkg.sv | 33 +++
 rtl/lfsr_rng_if.sv | 14 +
 rtl/lfsr_core.sv | 59 +++++
 rtl/lfsr_rng.sv | 121 ++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared types and the maximal-length tap table for the lfsr_rng random source.
package lfsr_pkg;

    localparam int unsigned TAP_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRAW,
        ST_HOLD
    } draw_state_e;

    // Tap mask for an XNOR Fibonacci LFSR; tap n sits at bit n-1.
    function automatic logic [TAP_W-1:0] lfsr_taps(input int unsigned width);
        case (width)
            3:       lfsr_taps = 16'h0006; // 3,2
            4:       lfsr_taps = 16'h000C; // 4,3
            5:       lfsr_taps = 16'h0014; // 5,3
            6:       lfsr_taps = 16'h0030; // 6,5
            7:       lfsr_taps = 16'h0060; // 7,6
            8:       lfsr_taps = 16'h00B8; // 8,6,5,4
            9:       lfsr_taps = 16'h0110; // 9,5
            10:      lfsr_taps = 16'h0240; // 10,7
            11:      lfsr_taps = 16'h0500; // 11,9
            12:      lfsr_taps = 16'h0829; // 12,6,4,1
            13:      lfsr_taps = 16'h100D; // 13,4,3,1
            14:      lfsr_taps = 16'h2015; // 14,5,3,1
            15:      lfsr_taps = 16'h6000; // 15,14
            16:      lfsr_taps = 16'hD008; // 16,15,13,4
            default: lfsr_taps = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/lfsr_rng_if.sv
// Request/valid/ack draw port of the random source.
interface lfsr_rng_if #(
    parameter int unsigned OUT_W = 2
) ();
    logic             req;
    logic             ready;
    logic             valid;
    logic [OUT_W-1:0] value;
    logic             ack;
    logic             biased;

    modport master (output req, ack, input ready, valid, value, biased);
    modport slave  (input req, ack, output ready, valid, value, biased);
endinterface

// File: rtl/lfsr_core.sv
// XNOR Fibonacci LFSR with seed load, wrap detection and all-ones recovery.
module lfsr_core
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned CAND_W       = 2,
    parameter int unsigned SEED_DEFAULT = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              step,
    input  logic              load,
    input  logic [WIDTH-1:0]  seed,
    output logic [WIDTH-1:0]  state,
    output logic [CAND_W-1:0] cand_c,
    output logic              wrapped,
    output logic              lockup
);
    localparam logic [WIDTH-1:0] ONES      = '1;
    localparam logic [WIDTH-1:0] TAPS      = WIDTH'(lfsr_taps(WIDTH));
    localparam logic [WIDTH-1:0] SEED_RAW  = WIDTH'(SEED_DEFAULT);
    localparam logic [WIDTH-1:0] SEED_INIT = (SEED_RAW == ONES) ? '0 : SEED_RAW;

    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] next_c;

    assign next_c = {state[WIDTH-2:0], ~^(state & TAPS)};
    assign cand_c = next_c[CAND_W-1:0];

    // Load beats lock-up recovery, which beats a normal step.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state   <= SEED_INIT;
            start   <= SEED_INIT;
            wrapped <= 1'b0;
            lockup  <= 1'b0;
        end else begin
            wrapped <= 1'b0;
            lockup  <= 1'b0;
            if (load) begin
                if (seed == ONES) begin
                    state  <= '0;
                    start  <= '0;
                    lockup <= 1'b1;
                end else begin
                    state <= seed;
                    start <= seed;
                end
            end else if (state == ONES) begin
                state  <= '0;
                lockup <= 1'b1;
            end else if (step) begin
                state   <= next_c;
                wrapped <= (next_c == start);
            end
        end
    end

endmodule

// File: rtl/lfsr_rng.sv
// Game-wide random source: free-running LFSR plus an unbiased rejection-sampled draw port.
module lfsr_rng
    import lfsr_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned OUT_W        = 2,
    parameter int unsigned RANGE        = 4,
    parameter int unsigned MAX_TRIES    = 8,
    parameter int unsigned SEED_DEFAULT = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    output logic [WIDTH-1:0] state,
    output logic             wrapped,
    output logic             lockup,
    lfsr_rng_if.slave        draw
);
    localparam logic [OUT_W:0] RANGE_W = (OUT_W + 1)'(RANGE);
    localparam logic [7:0]     MAX_T   = 8'(MAX_TRIES);

    if (WIDTH < 3 || WIDTH > 16) begin : g_bad_width
        $error("lfsr_rng: WIDTH must be 3..16");
    end
    if (OUT_W != $clog2(RANGE) || OUT_W > WIDTH) begin : g_bad_out_w
        $error("lfsr_rng: OUT_W must equal clog2(RANGE) and not exceed WIDTH");
    end
    if (RANGE < 2) begin : g_bad_range
        $error("lfsr_rng: RANGE must be at least 2");
    end
    if (MAX_TRIES < 1 || MAX_TRIES > 255) begin : g_bad_tries
        $error("lfsr_rng: MAX_TRIES must be 1..255");
    end

    draw_state_e      fsm;
    logic             ready_q;
    logic             valid_q;
    logic             biased_q;
    logic [OUT_W-1:0] value_q;
    logic [7:0]       tries;
    logic [OUT_W-1:0] cand_c;
    logic             step_c;

    assign step_c = (fsm == ST_DRAW) || enable;

    lfsr_core #(
        .WIDTH        (WIDTH),
        .CAND_W       (OUT_W),
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_core (
        .clock   (clock),
        .reset   (reset),
        .step    (step_c),
        .load    (load),
        .seed    (seed),
        .state   (state),
        .cand_c  (cand_c),
        .wrapped (wrapped),
        .lockup  (lockup)
    );

    assign draw.ready  = ready_q;
    assign draw.valid  = valid_q;
    assign draw.value  = value_q;
    assign draw.biased = biased_q;

    // Draw FSM: accept in IDLE, sample candidates in DRAW, present result in HOLD.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fsm      <= ST_IDLE;
            ready_q  <= 1'b1;
            valid_q  <= 1'b0;
            value_q  <= '0;
            tries    <= '0;
            biased_q <= 1'b0;
        end else begin
            biased_q <= 1'b0;
            case (fsm)
                ST_IDLE: begin
                    if (draw.req && ready_q) begin
                        fsm     <= ST_DRAW;
                        ready_q <= 1'b0;
                        tries   <= '0;
                    end
                end
                ST_DRAW: begin
                    // A load steals the edge: no candidate, no try consumed.
                    if (!load) begin
                        if ({1'b0, cand_c} < RANGE_W) begin
                            value_q <= cand_c;
                            valid_q <= 1'b1;
                            fsm     <= ST_HOLD;
                        end else if (tries + 8'd1 == MAX_T) begin
                            value_q  <= OUT_W'({1'b0, cand_c} - RANGE_W);
                            valid_q  <= 1'b1;
                            biased_q <= 1'b1;
                            fsm      <= ST_HOLD;
                        end else begin
                            tries <= tries + 8'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    if (draw.ack) begin
                        fsm     <= ST_IDLE;
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                    end
                end
                default: begin
                    fsm     <= ST_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
